// File: rtl/fetch_predictor_if.sv
// Fetch-predictor bus: fetch control and EX training into the predictor,
// fetch PC and prediction back out to imem and the IF/ID register.
interface fetch_predictor_if #(
   parameter int PIDX = 5
);
   logic            stall;
   logic            redirect_valid;
   logic [31:0]     redirect_pc;
   logic            ex_update_en;
   logic            ex_is_cond;
   logic            ex_actual_taken;
   logic [1:0]      ex_br_type;
   logic [31:0]     ex_pc;
   logic [31:0]     ex_actual_target;
   logic [PIDX-1:0] ex_pht_idx;
   logic [31:0]     F_PC;
   logic [31:0]     next_pc;
   logic            F_pred_taken;
   logic [PIDX-1:0] F_pht_idx;
   logic            F_btb_hit;
   logic [31:0]     F_pred_target;

   modport master (
      output stall, redirect_valid, redirect_pc, ex_update_en, ex_is_cond,
             ex_actual_taken, ex_br_type, ex_pc, ex_actual_target, ex_pht_idx,
      input  F_PC, next_pc, F_pred_taken, F_pht_idx, F_btb_hit, F_pred_target
   );

   modport slave (
      input  stall, redirect_valid, redirect_pc, ex_update_en, ex_is_cond,
             ex_actual_taken, ex_br_type, ex_pc, ex_actual_target, ex_pht_idx,
      output F_PC, next_pc, F_pred_taken, F_pht_idx, F_btb_hit, F_pred_target
   );
endinterface

// File: rtl/fetch_predictor.sv
// Fetch-PC unit: PC register, gshare direction predictor, tagged direct-mapped
// BTB and a circular return-address stack, trained by EX resolution.
module fetch_predictor #(
   parameter int          PHT_ENTRIES = 32,
   parameter int          GHR_LEN     = 5,
   parameter int          BTB_ENTRIES = 16,
   parameter int          RAS_DEPTH   = 4,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input logic              clk,
   input logic              rst,
   fetch_predictor_if.slave fp
);
   localparam int PIDX = $clog2(PHT_ENTRIES);
   localparam int BIDX = $clog2(BTB_ENTRIES);
   localparam int TAGW = 30 - BIDX;
   localparam int RPW  = $clog2(RAS_DEPTH);
   localparam int RCW  = $clog2(RAS_DEPTH + 1);

   localparam logic [1:0] BR_COND = 2'd0;
   localparam logic [1:0] BR_CALL = 2'd2;
   localparam logic [1:0] BR_RET  = 2'd3;

   logic [31:0]        pc_q, pc_d, pc_plus4;
   logic [GHR_LEN-1:0] ghr_q, ghr_d;
   logic [1:0]         pht_q [PHT_ENTRIES];
   logic [1:0]         pht_d;
   logic               btb_valid_q [BTB_ENTRIES];
   logic [TAGW-1:0]    btb_tag_q [BTB_ENTRIES];
   logic [31:0]        btb_tgt_q [BTB_ENTRIES];
   logic [1:0]         btb_type_q [BTB_ENTRIES];
   logic [31:0]        ras_q [RAS_DEPTH];
   logic [RPW-1:0]     ras_ptr_q, ras_ptr_inc, ras_ptr_dec;
   logic [RCW-1:0]     ras_cnt_q;

   logic [PIDX-1:0]    pht_idx;
   logic [BIDX-1:0]    f_btb_idx, ex_btb_idx;
   logic [1:0]         f_type;
   logic               btb_hit, pred_taken, fire, push, pop;
   logic [31:0]        pred_target;
   logic               unused_ex_pc_bits;

   assign pc_plus4          = pc_q + 32'd4;
   assign pht_idx           = pc_q[PIDX+1:2] ^ PIDX'(ghr_q);
   assign f_btb_idx         = pc_q[BIDX+1:2];
   assign ex_btb_idx        = fp.ex_pc[BIDX+1:2];
   assign f_type            = btb_type_q[f_btb_idx];
   assign btb_hit           = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == pc_q[31:BIDX+2]);
   assign unused_ex_pc_bits = ^fp.ex_pc[1:0];

   // A return with an empty stack falls back to the BTB target.
   always_comb begin
      pred_taken  = 1'b0;
      pred_target = 32'h0;
      if (btb_hit) begin
         pred_target = btb_tgt_q[f_btb_idx];
         pred_taken  = 1'b1;
         if (f_type == BR_COND) begin
            pred_taken = pht_q[pht_idx][1];
         end else if ((f_type == BR_RET) && (ras_cnt_q != '0)) begin
            pred_target = ras_q[ras_ptr_q];
         end
      end
   end

   assign fire = !fp.stall && !fp.redirect_valid;
   assign push = fire && btb_hit && (f_type == BR_CALL);
   assign pop  = fire && btb_hit && (f_type == BR_RET) && (ras_cnt_q != '0);

   always_comb begin
      if (fp.redirect_valid)  pc_d = fp.redirect_pc;
      else if (fp.stall)      pc_d = pc_q;
      else if (pred_taken)    pc_d = pred_target;
      else                    pc_d = pc_plus4;
   end

   assign ras_ptr_inc = (ras_ptr_q == RPW'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + RPW'(1);
   assign ras_ptr_dec = (ras_ptr_q == '0) ? RPW'(RAS_DEPTH - 1) : ras_ptr_q - RPW'(1);

   always_comb begin
      pht_d = pht_q[fp.ex_pht_idx];
      if (fp.ex_actual_taken) begin
         if (pht_d != 2'b11) pht_d = pht_d + 2'd1;
      end else if (pht_d != 2'b00) begin
         pht_d = pht_d - 2'd1;
      end
   end

   assign ghr_d = GHR_LEN'({ghr_q, fp.ex_actual_taken});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= 32'h0;
      end else begin
         pc_q <= pc_d;
         if (push) begin
            ras_q[ras_ptr_inc] <= pc_plus4;
            ras_ptr_q          <= ras_ptr_inc;
            if (ras_cnt_q != RCW'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + RCW'(1);
         end else if (pop) begin
            ras_ptr_q <= ras_ptr_dec;
            ras_cnt_q <= ras_cnt_q - RCW'(1);
         end
      end
   end

   // Training is independent of stall; GHR is only ever advanced from EX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
         for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
      end else if (fp.ex_update_en && fp.ex_is_cond) begin
         pht_q[fp.ex_pht_idx] <= pht_d;
         ghr_q                <= ghr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_q[i] <= 1'b0;
            btb_tag_q[i]   <= '0;
            btb_tgt_q[i]   <= 32'h0;
            btb_type_q[i]  <= 2'd0;
         end
      end else if (fp.ex_update_en && fp.ex_actual_taken) begin
         btb_valid_q[ex_btb_idx] <= 1'b1;
         btb_tag_q[ex_btb_idx]   <= fp.ex_pc[31:BIDX+2];
         btb_tgt_q[ex_btb_idx]   <= fp.ex_actual_target;
         btb_type_q[ex_btb_idx]  <= fp.ex_br_type;
      end
   end

   assign fp.F_PC          = pc_q;
   assign fp.next_pc       = pc_d;
   assign fp.F_pred_taken  = pred_taken;
   assign fp.F_pht_idx     = pht_idx;
   assign fp.F_btb_hit     = btb_hit;
   assign fp.F_pred_target = pred_target;
endmodule

// File: tb/tb_fetch_predictor.sv
// Bench for fetch_predictor: directed scenarios then random traffic, all
// compared against a queue/array reference model of the predictor.
module tb_fetch_predictor;
   localparam int PHT_N = 32;
   localparam int BTB_N = 16;
   localparam int RAS_N = 4;

   logic clk;
   logic rst;
   fetch_predictor_if #(.PIDX(5)) bus ();

   fetch_predictor #(
      .PHT_ENTRIES(PHT_N), .GHR_LEN(5), .BTB_ENTRIES(BTB_N),
      .RAS_DEPTH(RAS_N), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst(rst), .fp(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int testCount = 0;
   int failCount = 0;

   logic [31:0] mPc;
   int          mGhr;
   int          mPht [PHT_N];
   bit          mBtbValid [BTB_N];
   logic [31:0] mBtbPc [BTB_N];
   logic [31:0] mBtbTgt [BTB_N];
   int          mBtbType [BTB_N];
   logic [31:0] mRas [$];

   bit          sStall, sRedir, sUpd, sCond, sTaken;
   logic [31:0] sRpc, sExPc, sExTgt;
   int          sType, sExIdx;

   bit          pHit, pTaken;
   int          pKind, pIdx;
   logic [31:0] pTgt, pNext;

   logic [31:0] chain [11];
   bit          rSt, rRd, rUpd, rCond, rTk;
   int          rType;

   task automatic modelReset();
      mPc  = 32'h0;
      mGhr = 0;
      for (int i = 0; i < PHT_N; i++) mPht[i] = 1;
      for (int i = 0; i < BTB_N; i++) mBtbValid[i] = 1'b0;
      mRas.delete();
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit stall, input bit redir, input logic [31:0] rpc,
                                input bit upd, input bit cond, input bit taken, input int brType,
                                input logic [31:0] exPc, input logic [31:0] exTgt, input int exIdx);
      @(negedge clk);
      sStall = stall; sRedir = redir; sRpc = rpc; sUpd = upd; sCond = cond; sTaken = taken;
      sType = brType; sExPc = exPc; sExTgt = exTgt; sExIdx = exIdx;
      bus.stall            = stall;
      bus.redirect_valid   = redir;
      bus.redirect_pc      = rpc;
      bus.ex_update_en     = upd;
      bus.ex_is_cond       = cond;
      bus.ex_actual_taken  = taken;
      bus.ex_br_type       = 2'(brType);
      bus.ex_pc            = exPc;
      bus.ex_actual_target = exTgt;
      bus.ex_pht_idx       = 5'(exIdx);
      #1;
   endtask

   // Prediction straight from the rules: BTB lookup by word address, gshare
   // index, and the top of the return stack for returns.
   task automatic checkOutput();
      int b;
      b      = int'((mPc >> 2) % BTB_N);
      pIdx   = int'((mPc >> 2) % PHT_N) ^ mGhr;
      pHit   = mBtbValid[b] && ((mBtbPc[b] >> 6) == (mPc >> 6));
      pTaken = 1'b0;
      pTgt   = 32'h0;
      pKind  = -1;
      if (pHit) begin
         pKind  = mBtbType[b];
         pTgt   = mBtbTgt[b];
         pTaken = 1'b1;
         if (pKind == 0) pTaken = (mPht[pIdx] >= 2);
         if (pKind == 3 && mRas.size() > 0) pTgt = mRas[$];
      end
      if (sRedir)      pNext = sRpc;
      else if (sStall) pNext = mPc;
      else if (pTaken) pNext = pTgt;
      else             pNext = mPc + 32'd4;
      checkVal("F_PC", bus.F_PC, mPc);
      checkVal("next_pc", bus.next_pc, pNext);
      checkVal("F_pred_taken", 32'(bus.F_pred_taken), 32'(pTaken));
      checkVal("F_pht_idx", 32'(bus.F_pht_idx), 32'(pIdx));
      checkVal("F_btb_hit", 32'(bus.F_btb_hit), 32'(pHit));
      if (pTaken || !pHit) checkVal("F_pred_target", bus.F_pred_target, pTgt);
   endtask

   task automatic advance();
      int b;
      bit fire;
      fire = !sStall && !sRedir;
      if (fire && pHit && pKind == 2) begin
         mRas.push_back(mPc + 32'd4);
         if (mRas.size() > RAS_N) void'(mRas.pop_front());
      end else if (fire && pHit && pKind == 3 && mRas.size() > 0) begin
         void'(mRas.pop_back());
      end
      if (sUpd && sCond) begin
         if (sTaken) mPht[sExIdx] = (mPht[sExIdx] == 3) ? 3 : mPht[sExIdx] + 1;
         else        mPht[sExIdx] = (mPht[sExIdx] == 0) ? 0 : mPht[sExIdx] - 1;
         mGhr = ((mGhr << 1) | int'(sTaken)) & 31;
      end
      if (sUpd && sTaken) begin
         b            = int'((sExPc >> 2) % BTB_N);
         mBtbValid[b] = 1'b1;
         mBtbPc[b]    = sExPc;
         mBtbTgt[b]   = sExTgt;
         mBtbType[b]  = sType;
      end
      mPc = pNext;
      @(posedge clk);
   endtask

   task automatic cyc(input bit stall, input bit redir, input logic [31:0] rpc);
      applyStimulus(stall, redir, rpc, 1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
      checkOutput();
   endtask

   task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input int brType,
                        input bit cond, input bit taken, input int idx);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, cond, taken, brType, pc, tgt, idx);
      checkOutput();
      advance();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      sStall = 0; sRedir = 0; sUpd = 0; sCond = 0; sTaken = 0;
      sRpc = 0; sExPc = 0; sExTgt = 0; sType = 0; sExIdx = 0;
      bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.ex_update_en = 0;
      bus.ex_is_cond = 0; bus.ex_actual_taken = 0; bus.ex_br_type = 0; bus.ex_pc = 0;
      bus.ex_actual_target = 0; bus.ex_pht_idx = 0;
      modelReset();
      @(posedge clk); #1;
      checkOutput();
      checkVal("reset_pc", bus.F_PC, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b0, 32'h0);
         checkVal("seq_pc", bus.F_PC, 32'(4 * k));
         checkVal("seq_idx", 32'(bus.F_pht_idx), 32'(k));
         advance();
      end

      train(32'h40, 32'h100, 0, 1'b1, 1'b1, 19);
      train(32'h40, 32'h100, 0, 1'b1, 1'b1, 19);
      cyc(1'b1, 1'b1, 32'h40); advance();
      cyc(1'b0, 1'b0, 32'h0);
      checkVal("cond_idx", 32'(bus.F_pht_idx), 32'd19);
      checkVal("cond_taken", 32'(bus.F_pred_taken), 32'd1);
      checkVal("cond_next", bus.next_pc, 32'h100);
      advance();
      train(32'h40, 32'h100, 0, 1'b1, 1'b0, 19);
      train(32'h3C, 32'h3C0, 0, 1'b1, 1'b0, 8);
      train(32'h3C, 32'h3C0, 0, 1'b1, 1'b0, 8);
      train(32'h3C, 32'h3C0, 0, 1'b1, 1'b1, 8);
      train(32'h3C, 32'h3C0, 0, 1'b1, 1'b1, 8);
      cyc(1'b1, 1'b1, 32'h40); advance();
      cyc(1'b0, 1'b0, 32'h0);
      checkVal("weak_taken_next", bus.next_pc, 32'h100);
      advance();

      train(32'h20, 32'h200, 2, 1'b0, 1'b1, 0);
      train(32'h204, 32'h999, 3, 1'b0, 1'b1, 0);
      cyc(1'b1, 1'b1, 32'h20); advance();
      cyc(1'b0, 1'b0, 32'h0); checkVal("call_pc", bus.F_PC, 32'h20); advance();
      cyc(1'b0, 1'b0, 32'h0); checkVal("callee_pc", bus.F_PC, 32'h200); advance();
      cyc(1'b0, 1'b0, 32'h0); checkVal("ret_target", bus.F_pred_target, 32'h24); advance();
      cyc(1'b0, 1'b0, 32'h0); checkVal("after_ret_pc", bus.F_PC, 32'h24); advance();

      chain = '{32'h1000, 32'h2008, 32'h3010, 32'h4018, 32'h5020, 32'h6028,
                32'h5024, 32'h401C, 32'h3014, 32'h200C, 32'hF00};
      for (int k = 0; k < 5; k++) train(chain[k], chain[k+1], 2, 1'b0, 1'b1, 0);
      for (int k = 5; k < 10; k++) train(chain[k], 32'hF00, 3, 1'b0, 1'b1, 0);
      cyc(1'b1, 1'b1, chain[0]); advance();
      for (int k = 0; k < 11; k++) begin
         cyc(1'b0, 1'b0, 32'h0);
         checkVal("nest_pc", bus.F_PC, chain[k]);
         advance();
      end

      cyc(1'b1, 1'b1, chain[0]); advance();
      for (int k = 0; k < 2; k++) begin
         cyc(1'b1, 1'b0, 32'h0);
         checkVal("stall_hit", 32'(bus.F_btb_hit), 32'd1);
         checkVal("stall_next", bus.next_pc, chain[0]);
         advance();
      end
      cyc(1'b1, 1'b1, 32'h80); checkVal("stall_redir_next", bus.next_pc, 32'h80); advance();
      cyc(1'b0, 1'b0, 32'h0); checkVal("redir_pc", bus.F_PC, 32'h80); advance();

      cyc(1'b1, 1'b1, chain[5]); advance();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1, chain[5], 32'h7000, 0);
      checkOutput();
      checkVal("old_btb_target", bus.F_pred_target, 32'hF00);
      advance();
      cyc(1'b1, 1'b0, 32'h0); checkVal("new_btb_target", bus.F_pred_target, 32'h7000); advance();
      cyc(1'b1, 1'b1, 32'hFFFF_FFFC); advance();
      cyc(1'b0, 1'b0, 32'h0); checkVal("wrap_next", bus.next_pc, 32'h0); advance();
      cyc(1'b0, 1'b0, 32'h0); checkVal("wrap_pc", bus.F_PC, 32'h0); advance();

      for (int n = 0; n < 400; n++) begin
         rSt   = ($urandom_range(0, 4) == 0);
         rRd   = ($urandom_range(0, 9) == 0);
         rUpd  = ($urandom_range(0, 1) == 1);
         rCond = ($urandom_range(0, 1) == 1);
         rTk   = ($urandom_range(0, 2) != 0);
         rType = rCond ? 0 : int'($urandom_range(1, 3));
         applyStimulus(rSt, rRd, 32'($urandom_range(0, 255)) << 2, rUpd, rCond, rTk, rType,
                       32'($urandom_range(0, 255)) << 2, 32'($urandom_range(0, 255)) << 2,
                       int'($urandom_range(0, PHT_N - 1)));
         checkOutput();
         advance();
      end

      @(negedge clk); #2;
      rst = 1'b1;
      sStall = 0; sRedir = 0; sUpd = 0;
      bus.stall = 0; bus.redirect_valid = 0; bus.ex_update_en = 0;
      modelReset();
      #1;
      checkOutput();
      checkVal("midrst_pc", bus.F_PC, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b0, 32'h0);
         checkVal("post_rst_pc", bus.F_PC, 32'(4 * k));
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
